// File: rtl/mult_share_arb.sv
// Round-robin front end that shares one pipelined multiplier among NREQ clients and routes
// each product back to its owner by tag. Define MULT_ARB_CHECK_EN to add the sticky err output.
module mult_share_arb #(
    parameter int N    = 8,
    parameter int M    = 4,
    parameter int NREQ = 4,
    parameter int LAT  = M
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_mult1,
    input  logic [NREQ*M-1:0] req_mult2,
    output logic [NREQ-1:0]   resp_valid,
    output logic [N+M-1:0]    resp_res,
    output logic              mul_data_rdy,
    output logic [N-1:0]      mul_mult1,
    output logic [M-1:0]      mul_mult2,
    input  logic              mul_res_rdy,
    input  logic [N+M-1:0]    mul_res,
    output logic              busy
`ifdef MULT_ARB_CHECK_EN
    ,
    output logic              err
`endif
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] above_ptr;
    logic [NREQ-1:0] pick_src;
    logic            transfer;
    logic [LAT:0]    tag_v;
    logic [IDW-1:0]  tag_id [LAT+1];

    // Requests above the pointer win first; otherwise wrap to the lowest asserted index.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        above_ptr = '0;
        grant_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            above_ptr[i] = (IDW'(i) > ptr);
        end
        pick_src = (|(req_valid & above_ptr)) ? (req_valid & above_ptr) : req_valid;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick_src[i]) grant_id = IDW'(i);
        end
        transfer  = rstn && (|req_valid);
        req_ready = transfer ? (ONE << grant_id) : '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (!rstn) begin
            ptr          <= IDW'(NREQ - 1);
            mul_data_rdy <= 1'b0;
            mul_mult1    <= '0;
            mul_mult2    <= '0;
            tag_v        <= '0;
            resp_valid   <= '0;
            resp_res     <= '0;
        end else begin
            mul_data_rdy <= transfer;
            if (transfer) begin
                ptr       <= grant_id;
                mul_mult1 <= req_mult1[grant_id*N +: N];
                mul_mult2 <= req_mult2[grant_id*M +: M];
            end
            tag_v <= {tag_v[LAT-1:0], transfer};
            if (tag_v[LAT]) begin
                resp_valid <= ONE << tag_id[LAT];
                resp_res   <= mul_res;
            end else begin
                resp_valid <= '0;
            end
        end
    end

    // NOTE: tag ids carry no reset; the matching valid bit alone decides whether an id means anything.
    always_ff @(posedge clk) begin
        tag_id[0] <= grant_id;
        for (int k = 1; k <= LAT; k++) begin
            tag_id[k] <= tag_id[k-1];
        end
    end

    assign busy = mul_data_rdy | (|tag_v);

`ifdef MULT_ARB_CHECK_EN
    // A result strobe that disagrees with the tag tail means the multiplier latency is not LAT.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (mul_res_rdy != tag_v[LAT]) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_res_rdy;
    assign unused_res_rdy = mul_res_rdy;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: behavioural multiplier, cycle-indexed expectation model, directed tests.
// Build with MULT_ARB_CHECK_EN defined to also cover the err output.
module tb_mult_share_arb;
    localparam int N     = 8;
    localparam int M     = 4;
    localparam int NREQ  = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_mult1 = '0;
    logic [NREQ*M-1:0] req_mult2 = '0;
    logic [NREQ-1:0]   resp_valid;
    logic [N+M-1:0]    resp_res;
    logic              mul_data_rdy;
    logic [N-1:0]      mul_mult1;
    logic [M-1:0]      mul_mult2;
    logic              mul_res_rdy;
    logic [N+M-1:0]    mul_res;
    logic              busy;
`ifdef MULT_ARB_CHECK_EN
    logic              err;
`endif

    int errors = 0;
    int checks = 0;

    mult_share_arb #(.N(N), .M(M), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mult1(req_mult1), .req_mult2(req_mult2),
        .resp_valid(resp_valid), .resp_res(resp_res),
        .mul_data_rdy(mul_data_rdy), .mul_mult1(mul_mult1), .mul_mult2(mul_mult2),
        .mul_res_rdy(mul_res_rdy), .mul_res(mul_res),
        .busy(busy)
`ifdef MULT_ARB_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural multiplier: strobe in cycle c -> product and strobe in cycle c+LAT. Never reset.
    logic           mm_v [LAT];
    logic [N+M-1:0] mm_p [LAT];
    logic           force_rdy = 1'b0;
    initial begin
        for (int i = 0; i < LAT; i++) begin
            mm_v[i] = 1'b0;
            mm_p[i] = '0;
        end
    end
    always @(posedge clk) begin
        logic           v;
        logic [N+M-1:0] p;
        v = mul_data_rdy;
        p = {{M{1'b0}}, mul_mult1} * {{N{1'b0}}, mul_mult2};
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            mm_v[i] = mm_v[i-1];
            mm_p[i] = mm_p[i-1];
        end
        mm_v[0] = v;
        mm_p[0] = p;
    end
    assign mul_res_rdy = mm_v[LAT-1] | force_rdy;
    assign mul_res     = mm_p[LAT-1];

    // Expectation model: events scheduled by absolute cycle number.
    int          cyc = 0;
    int          ptr = NREQ - 1;
    int          busy_until = -1;
    bit          iss_v  [DEPTH];
    logic [N-1:0] iss_m1 [DEPTH];
    logic [M-1:0] iss_m2 [DEPTH];
    bit          rsp_v  [DEPTH];
    int          rsp_id [DEPTH];
    int          rsp_val[DEPTH];
    bit          tail_v [DEPTH];
    logic [N-1:0] hold_m1 = '0;
    logic [M-1:0] hold_m2 = '0;
    int          hold_res = 0;
    bit          exp_err = 1'b0;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int s;
        int g;
        s = cyc % DEPTH;
        if (iss_v[s]) begin
            hold_m1 = iss_m1[s];
            hold_m2 = iss_m2[s];
        end
        if (rsp_v[s]) hold_res = rsp_val[s];
        g = rr_pick(req_valid, ptr);
        check("mul_data_rdy", 64'(mul_data_rdy), 64'(iss_v[s]));
        check("mul_mult1", 64'(mul_mult1), 64'(hold_m1));
        check("mul_mult2", 64'(mul_mult2), 64'(hold_m2));
        check("resp_valid", 64'(resp_valid), rsp_v[s] ? 64'(1 << rsp_id[s]) : 64'(0));
        check("resp_res", 64'(resp_res), 64'(hold_res));
        check("busy", 64'(busy), 64'(cyc <= busy_until));
        check("req_ready", 64'(req_ready), (rstn && g >= 0) ? 64'(1 << g) : 64'(0));
`ifdef MULT_ARB_CHECK_EN
        check("err", 64'(err), 64'(exp_err));
        if (rstn && (mul_res_rdy !== tail_v[s])) exp_err = 1'b1;
`endif
        iss_v[s]  = 1'b0;
        rsp_v[s]  = 1'b0;
        tail_v[s] = 1'b0;
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                iss_v[i]  = 1'b0;
                rsp_v[i]  = 1'b0;
                tail_v[i] = 1'b0;
            end
            ptr        = NREQ - 1;
            hold_m1    = '0;
            hold_m2    = '0;
            hold_res   = 0;
            busy_until = -1;
            exp_err    = 1'b0;
        end else if (g >= 0) begin
            ptr = g;
            iss_v [(cyc + 1) % DEPTH]         = 1'b1;
            iss_m1[(cyc + 1) % DEPTH]         = req_mult1[g*N +: N];
            iss_m2[(cyc + 1) % DEPTH]         = req_mult2[g*M +: M];
            tail_v[(cyc + 1 + LAT) % DEPTH]   = 1'b1;
            rsp_v [(cyc + 2 + LAT) % DEPTH]   = 1'b1;
            rsp_id[(cyc + 2 + LAT) % DEPTH]   = g;
            rsp_val[(cyc + 2 + LAT) % DEPTH]  = int'(req_mult1[g*N +: N]) * int'(req_mult2[g*M +: M]);
            busy_until = cyc + 1 + LAT;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_mult1[i*N +: N] = N'(a);
        req_mult2[i*M +: M] = M'(b);
    endtask

    task automatic do_reset();
        step();
        rstn      = 1'b0;
        req_valid = '0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        sample();
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_resp_valid", 64'(resp_valid), 64'(0));
        step();
        rstn = 1'b1;

        // Single transfer 25x5 from requester 0.
        step();
        set_op(0, 25, 5);
        req_valid = 4'b0001;
        sample();
        check("t1_ready", 64'(req_ready), 64'(4'b0001));
        step();
        req_valid = '0;
        sample();
        check("t1_issue", 64'(mul_data_rdy), 64'(1));
        check("t1_mult1", 64'(mul_mult1), 64'(25));
        check("t1_mult2", 64'(mul_mult2), 64'(5));
        for (int k = 2; k <= 5; k++) begin
            step();
            sample();
            check("t1_no_resp", 64'(resp_valid), 64'(0));
            if (k == 2) check("t1_issue_once", 64'(mul_data_rdy), 64'(0));
        end
        step();
        sample();
        check("t1_resp_valid", 64'(resp_valid), 64'(4'b0001));
        check("t1_resp_res", 64'(resp_res), 64'(125));
        step();
        sample();
        check("t1_busy_low", 64'(busy), 64'(0));

        // All four requesters valid: grant order 0,1,2,3,... and results on consecutive cycles.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 10 + i, i + 1);
        for (int k = 0; k < 10; k++) begin
            step();
            req_valid = (k < 8) ? 4'hF : 4'h0;
            sample();
            if (k < 8) check("t2_ready", 64'(req_ready), 64'(1 << (k % 4)));
            if (k >= 6) begin
                check("t2_resp_valid", 64'(resp_valid), 64'(1 << (k - 6)));
                check("t2_resp_res", 64'(resp_res), 64'((10 + k - 6) * (k - 6 + 1)));
            end
        end

        // Lone requester 2, back-to-back, ending with the 255x15 maximum.
        for (int k = 0; k <= 38; k++) begin
            step();
            if (k <= 32) begin
                req_valid = 4'b0100;
                set_op(2, (k < 32) ? k : 255, 15);
            end else begin
                req_valid = '0;
            end
            sample();
            if (k <= 32) check("t3_ready", 64'(req_ready), 64'(4'b0100));
            if (k >= 6) begin
                check("t3_resp_valid", 64'(resp_valid), 64'(4'b0100));
                check("t3_resp_res", 64'(resp_res), 64'(15 * (((k - 6) < 32) ? (k - 6) : 255)));
            end
        end

        // Requester 1 competes with 0 and 3; bounded wait, operands taken in its grant cycle.
        begin
            int waited;
            bit got;
            waited = 0;
            got    = 1'b0;
            step();
            set_op(0, 3, 3);
            set_op(3, 7, 2);
            set_op(1, 77, 9);
            req_valid = 4'b1011;
            for (int w = 0; w < 8 && !got; w++) begin
                sample();
                if (req_ready[1]) begin
                    got = 1'b1;
                end else begin
                    step();
                    waited++;
                end
            end
            check("t4_granted", 64'(got), 64'(1));
            check("t4_wait_bound", 64'(waited <= 3), 64'(1));
            step();
            req_valid = 4'b1001;
            sample();
            check("t4_mult1", 64'(mul_mult1), 64'(77));
            check("t4_mult2", 64'(mul_mult2), 64'(9));
            step();
            req_valid = '0;
            repeat (8) step();
        end

        // Three issues in flight, then reset: nothing delivered, priority back to lowest index.
        set_op(0, 20, 3);
        set_op(1, 21, 4);
        set_op(2, 22, 5);
        step();
        req_valid = 4'b0111;
        step();
        step();
        step();
        req_valid = '0;
        rstn      = 1'b0;
        step();
        rstn = 1'b1;
        set_op(3, 9, 9);
        req_valid = 4'b1010;
        sample();
        check("t5_busy_after_reset", 64'(busy), 64'(0));
        check("t5_ready_lowest", 64'(req_ready), 64'(4'b0010));
        for (int j = 1; j <= 6; j++) begin
            step();
            if (j == 1) req_valid = '0;
            sample();
            if (j < 6) begin
                check("t5_dropped", 64'(resp_valid), 64'(0));
            end else begin
                check("t5_resp_valid", 64'(resp_valid), 64'(4'b0010));
                check("t5_resp_res", 64'(resp_res), 64'(84));
            end
        end

        // Spurious mul_res_rdy with an empty tag pipe.
        repeat (4) step();
        do_reset();
        step();
        sample();
`ifdef MULT_ARB_CHECK_EN
        check("t6_err_clear", 64'(err), 64'(0));
`endif
        step();
        force_rdy = 1'b1;
        step();
        force_rdy = 1'b0;
        sample();
        check("t6_no_resp", 64'(resp_valid), 64'(0));
`ifdef MULT_ARB_CHECK_EN
        check("t6_err_set", 64'(err), 64'(1));
`endif
        repeat (3) begin
            step();
            sample();
            check("t6_no_resp_hold", 64'(resp_valid), 64'(0));
`ifdef MULT_ARB_CHECK_EN
            check("t6_err_sticky", 64'(err), 64'(1));
`endif
        end
        do_reset();
        sample();
`ifdef MULT_ARB_CHECK_EN
        check("t6_err_reset", 64'(err), 64'(0));
`endif
        check("t6_idle_busy", 64'(busy), 64'(0));

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
